systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
// - Producer side of the MAC array: packs a streamed activation frame into the LANES*DW in_r vector.
// - Sequences a weight stream onto w_r, one array compute cycle per accepted weight.
// - Gates the array via stop_proc (1 = array clock frozen); flushes the MAC pipeline; pulses done.
// PARAMETERS
// - LANES    1024  number of MAC lanes (in_r width = LANES*DW); must be a multiple of BEAT
// - DW       8     activation/weight width
// - BEAT     32    activation bytes accepted per s_valid/s_ready beat
// - PIPE_LAT 3     MAC pipeline depth; number of flush cycles after the last weight
// - CNT_W    16    width of weight counter / n_w
// PORTS
// - clk        in   1           single clock, rising edge
// - rst        in   1           asynchronous, active-low reset
// - start      in   1           frame start pulse; sampled only in IDLE
// - n_w        in   CNT_W       weights in this frame; latched on start
// - sel_in     in   1           MAC precision select; latched on start
// - s_data     in   DW*BEAT     activation beat; byte 0 = lowest lane of the beat
// - s_valid    in   1           activation beat valid
// - s_ready    out  1           activation beat accepted when s_valid & s_ready
// - w_data     in   DW          weight
// - w_valid    in   1           weight valid
// - w_ready    out  1           weight accepted when w_valid & w_ready
// - in_r       out  LANES*DW    activation vector to the array
// - w_r        out  DW          weight to the array
// - sel        out  1           latched sel_in
// - stop_proc  out  1           1 = array frozen, 0 = array clocked this cycle
// - arr_rst    out  1           one-cycle clear of array accumulators (active-high, as the MACs expect)
// - busy       out  1           high in every state except IDLE
// - done       out  1           one-cycle pulse at frame completion
// BEHAVIOUR
// - Reset (rst=0, async): in_r=0, w_r=0, sel=0, stop_proc=1, arr_rst=0, s_ready=0, w_ready=0, busy=0, done=0.
//   All counters 0; state IDLE. Reset mid-frame discards the frame with no done pulse.
// - FSM: IDLE -> CLEAR -> LOAD -> COMPUTE -> DRAIN -> DONE -> IDLE. All outputs are registered.
// - IDLE: start=1 latches n_w and sel_in and moves to CLEAR; start outside IDLE is ignored.
// - CLEAR: exactly one cycle; arr_rst=1, stop_proc=1.
// - LOAD: s_ready=1. Beat k (k = 0..LANES/BEAT-1) writes in_r[DW*BEAT*k +: DW*BEAT].
//   The last beat moves to COMPUTE, or to DONE if latched n_w==0; DRAIN is skipped when n_w==0.
//   s_ready drops in the cycle after the last beat; no extra beat is accepted.
// - COMPUTE: w_ready=1 while accepted < n_w. A handshake at edge t gives w_r<=w_data at t and
//   stop_proc=0 for the cycle after t. With no handshake, stop_proc=1 (array held).
//   After the n_w-th handshake, w_ready drops next cycle and the FSM enters DRAIN.
// - DRAIN: w_r=0, stop_proc=0 for exactly PIPE_LAT cycles, then stop_proc=1 and go to DONE.
// - DONE: done=1 for one cycle, busy=0 next cycle, state IDLE.
// - in_r and sel hold their values from the end of LOAD until the next CLEAR.
//   in_r is never cleared except by reset.
// - Back-to-back weights: one weight per cycle; stop_proc stays 0 continuously.
// - Weight counter: CNT_W bits, no wrap; n_w = 2^CNT_W-1 is a legal maximum.
// - Frame latency, full-rate handshakes: 1 + LANES/BEAT + n_w + PIPE_LAT + 1 cycles from start to done.
// CONFIGURATION
// - FEEDER_ABORT_EN defined: adds input port abort (1 bit).
//   abort=1 in any non-IDLE state -> next cycle: state IDLE, stop_proc=1, s_ready=0, w_ready=0,
//   busy=0, no done pulse. in_r and w_r keep their last values.
//   abort has priority over any handshake in the same cycle; that handshake is not consumed.
//   abort in IDLE has no effect.
// - FEEDER_ABORT_EN undefined: no abort port; a frame runs only to DONE or reset.
// TESTING
// - Reset: drive rst=0 mid-COMPUTE -> all outputs at reset values immediately; busy=0; no done pulse.
// - Full frame, defaults: start, n_w=4, 32 beats with byte value = lane index mod 256, weights 1,2,3,4
//   back-to-back -> in_r[8*i+:8]==i mod 256; stop_proc=0 for 4+3 cycles; done at cycle 1+32+4+3+1=41.
// - Stalls: s_valid toggling 1/0, w_valid gaps of 2 cycles -> stop_proc=1 during gaps;
//   w_r changes only on handshakes; the result matches the no-stall run.
// - n_w=0: start, load 32 beats -> no stop_proc=0 cycle and no DRAIN; done 1 cycle after the last beat.
// - Start while busy: pulse start in LOAD with n_w=9 -> ignored; the latched n_w stays 4; exactly one done.
// - FEEDER_ABORT_EN: abort during COMPUTE concurrent with w_valid -> weight not consumed; IDLE next
//   cycle; no done. A new start then completes normally.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Activation beat and weight stream handshakes for systolic_feeder.
interface systolic_feeder_if #(
  parameter int DW   = 8,
  parameter int BEAT = 32
);
  logic [DW*BEAT-1:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      w_data;
  logic               w_valid;
  logic               w_ready;

  modport master (
    output s_data, s_valid, w_data, w_valid,
    input  s_ready, w_ready
  );
  modport slave (
    input  s_data, s_valid, w_data, w_valid,
    output s_ready, w_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// Packs activation beats into in_r, sequences weights onto w_r, gates the MAC array.
// Optional FEEDER_ABORT_EN adds an abort input that drops any frame back to IDLE.
module systolic_feeder #(
  parameter int LANES    = 1024,
  parameter int DW       = 8,
  parameter int BEAT     = 32,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    n_w,
  input  logic                sel_in,
`ifdef FEEDER_ABORT_EN
  input  logic                abort,
`endif
  systolic_feeder_if.slave    bus,
  output logic [LANES*DW-1:0] in_r,
  output logic [DW-1:0]       w_r,
  output logic                sel,
  output logic                stop_proc,
  output logic                arr_rst,
  output logic                busy,
  output logic                done
);
  localparam int NB  = LANES / BEAT;
  localparam int BW  = DW * BEAT;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DCW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_COMP, S_DRAIN, S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [LANES*DW-1:0] r_in;
  logic [DW-1:0]       r_w;
  logic                r_sel;
  logic [CNT_W-1:0]    r_nw;
  logic [CNT_W-1:0]    r_wcnt;
  logic [BCW-1:0]      r_beat;
  logic [DCW-1:0]      r_dcnt;
  logic                r_s_ready;
  logic                r_w_ready;
  logic                r_stop;
  logic                r_arr_rst;
  logic                r_busy;
  logic                r_done;

  logic                w_abort;
  logic                w_s_hs;
  logic                w_w_hs;
  logic                w_last_beat;
  logic                w_last_w;
  logic                w_drain_end;
  logic [CNT_W-1:0]    w_wcnt_inc;
  logic                w_stop_d;
  logic [DW-1:0]       w_wr_d;

`ifdef FEEDER_ABORT_EN
  assign w_abort = abort & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // an aborted cycle must not consume a pending handshake
  assign w_s_hs      = bus.s_valid & r_s_ready & ~w_abort;
  assign w_w_hs      = bus.w_valid & r_w_ready & ~w_abort;
  assign w_last_beat = (r_beat == BCW'(NB - 1));
  assign w_wcnt_inc  = r_wcnt + CNT_W'(1);
  assign w_last_w    = (w_wcnt_inc == r_nw);
  assign w_drain_end = (r_dcnt == DCW'(PIPE_LAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_nxt = S_CLEAR;
      S_CLEAR: w_nxt = S_LOAD;
      S_LOAD:
        if (w_s_hs && w_last_beat)
          w_nxt = (r_nw == '0) ? S_DONE : S_COMP;
      S_COMP:  if (w_w_hs && w_last_w) w_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_IDLE;
  end

  always_comb begin
    w_stop_d = 1'b1;
    w_wr_d   = r_w;
    if (r_state == S_COMP && w_w_hs) begin
      w_stop_d = 1'b0;
      w_wr_d   = bus.w_data;
    end
    if (r_state == S_DRAIN && !w_abort) begin
      w_wr_d = '0;
      if (w_nxt == S_DRAIN) w_stop_d = 1'b0;
    end
  end

  // outputs are registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_ready <= 1'b0;
      r_w_ready <= 1'b0;
      r_stop    <= 1'b1;
      r_arr_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w       <= '0;
    end else begin
      r_s_ready <= (w_nxt == S_LOAD);
      r_w_ready <= (w_nxt == S_COMP);
      r_stop    <= w_stop_d;
      r_arr_rst <= (w_nxt == S_CLEAR);
      r_busy    <= (w_nxt != S_IDLE);
      r_done    <= (w_nxt == S_DONE);
      r_w       <= w_wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in   <= '0;
      r_sel  <= 1'b0;
      r_nw   <= '0;
      r_wcnt <= '0;
      r_beat <= '0;
      r_dcnt <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_nw  <= n_w;
        r_sel <= sel_in;
      end
      if (r_state == S_CLEAR) begin
        r_beat <= '0;
        r_wcnt <= '0;
        r_dcnt <= '0;
      end
      if (w_s_hs) begin
        r_in[BW*r_beat +: BW] <= bus.s_data;
        r_beat                <= r_beat + 1'b1;
      end
      if (w_w_hs) r_wcnt <= w_wcnt_inc;
      if (r_state == S_DRAIN && !w_drain_end)
        r_dcnt <= r_dcnt + 1'b1;
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.w_ready = r_w_ready;
  assign in_r        = r_in;
  assign w_r         = r_w;
  assign sel         = r_sel;
  assign stop_proc   = r_stop;
  assign arr_rst     = r_arr_rst;
  assign busy        = r_busy;
  assign done        = r_done;
endmodule
